// File: rtl/inject_sched.sv
// inject_sched: local-injection scheduler for a mesh router.
// A small in-order FIFO buffers flits offered by the local core.
// Whenever the head flit exists and at least one router output slot is
// free, the head is injected into the first free slot. The search for a
// free slot is round-robin. The injected flit and its slot are registered.
// A starvation counter raises starve_alarm when the FIFO has been blocked
// by fully occupied slots for STARVE_LIMIT consecutive edges.
//
// Ports:
//   clk, rst      single clock; asynchronous active-high reset
//   req_valid     local core offers req_flit
//   req_flit      10-bit flit word; carried through untouched
//   req_ready     FIFO has room (combinational from registered count)
//   slot_busy     output slot occupancy {W,E,S,N}; 1 = occupied
//   inj_valid     registered; flit injected this cycle
//   inj_flit      registered injected flit; holds when idle
//   inj_sel       registered one-hot slot select {W,E,S,N}
//   fifo_count    current FIFO occupancy
//   starve_alarm  registered; blocked for STARVE_LIMIT edges
module inject_sched #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    input  logic [9:0]             req_flit,
    output logic                   req_ready,
    input  logic [3:0]             slot_busy,
    output logic                   inj_valid,
    output logic [9:0]             inj_flit,
    output logic [3:0]             inj_sel,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   starve_alarm
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_LIMIT) + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [SW-1:0] STARVE_C = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_READY   = 2'd1,
        ST_BLOCKED = 2'd2
    } state_t;

    // First free slot at or after ptr, wrapping modulo 4. Only meaningful
    // when at least one slot is free; the caller gates on that.
    function automatic logic [1:0] pick_slot(input logic [3:0] busy,
                                             input logic [1:0] ptr);
        logic [1:0] idx;
        logic [1:0] cand;
        logic       found;
        idx   = ptr;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cand = ptr + 2'(k);
            if (!found && !busy[cand]) begin
                idx   = cand;
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return idx;
    endfunction

    logic [9:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [1:0]    rr_ptr_q, rr_ptr_d;
    logic [SW-1:0] starve_q, starve_d;
    state_t        state_q, state_d;
    logic          inj_valid_q, inj_valid_d;
    logic [9:0]    inj_flit_q, inj_flit_d;
    logic [3:0]    inj_sel_q, inj_sel_d;
    logic          alarm_q, alarm_d;

    logic          push_s;
    logic          pop_s;
    logic          free_s;
    logic [1:0]    slot_idx_s;

    assign req_ready    = (count_q < DEPTH_C);
    assign fifo_count   = count_q;
    assign inj_valid    = inj_valid_q;
    assign inj_flit     = inj_flit_q;
    assign inj_sel      = inj_sel_q;
    assign starve_alarm = alarm_q;

    // Next-state logic: FIFO bookkeeping, slot choice, FSM and starvation.
    always_comb begin
        free_s      = (slot_busy != 4'b1111);
        push_s      = req_valid && (count_q < DEPTH_C);
        // Pop decision uses the registered count, so a freshly pushed flit
        // always spends at least one cycle in the FIFO.
        pop_s       = (count_q != {CW{1'b0}}) && free_s;
        slot_idx_s  = pick_slot(slot_busy, rr_ptr_q);

        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        rr_ptr_d    = rr_ptr_q;
        inj_valid_d = 1'b0;
        inj_flit_d  = inj_flit_q;
        inj_sel_d   = 4'b0000;
        state_d     = ST_IDLE;
        starve_d    = starve_q;
        alarm_d     = 1'b0;

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d    = rd_ptr_q + AW'(1);
            rr_ptr_d    = slot_idx_s + 2'd1;
            inj_valid_d = 1'b1;
            inj_flit_d  = mem_q[rd_ptr_q];
            inj_sel_d   = 4'b0001 << slot_idx_s;
        end else begin
            rd_ptr_d    = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (count_q == {CW{1'b0}}) begin
            state_d = ST_IDLE;
        end else if (free_s) begin
            state_d = ST_READY;
        end else begin
            state_d = ST_BLOCKED;
        end

        // A pop or a return to IDLE wins over the blocked-cycle increment.
        if (pop_s || (state_d == ST_IDLE)) begin
            starve_d = {SW{1'b0}};
        end else if ((state_q == ST_BLOCKED) && (starve_q != STARVE_C)) begin
            starve_d = starve_q + SW'(1);
        end else begin
            starve_d = starve_q;
        end

        // Alarm mirrors the counter value being registered this edge.
        alarm_d = (starve_d == STARVE_C);
    end

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= req_flit;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= {AW{1'b0}};
            rd_ptr_q    <= {AW{1'b0}};
            count_q     <= {CW{1'b0}};
            rr_ptr_q    <= 2'd0;
            starve_q    <= {SW{1'b0}};
            state_q     <= ST_IDLE;
            inj_valid_q <= 1'b0;
            inj_flit_q  <= 10'b0;
            inj_sel_q   <= 4'b0000;
            alarm_q     <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rr_ptr_q    <= rr_ptr_d;
            starve_q    <= starve_d;
            state_q     <= state_d;
            inj_valid_q <= inj_valid_d;
            inj_flit_q  <= inj_flit_d;
            inj_sel_q   <= inj_sel_d;
            alarm_q     <= alarm_d;
        end
    end

endmodule

// File: tb/tb_inject_sched.sv
module tb_inject_sched;

    logic       clk;
    logic       rst;
    logic       req_valid;
    logic [9:0] req_flit;
    logic       req_ready;
    logic [3:0] slot_busy;
    logic       inj_valid;
    logic [9:0] inj_flit;
    logic [3:0] inj_sel;
    logic [2:0] fifo_count;
    logic       starve_alarm;

    int total;
    int bad;

    inject_sched #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_flit     (req_flit),
        .req_ready    (req_ready),
        .slot_busy    (slot_busy),
        .inj_valid    (inj_valid),
        .inj_flit     (inj_flit),
        .inj_sel      (inj_sel),
        .fifo_count   (fifo_count),
        .starve_alarm (starve_alarm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    task automatic chk_pop(input string tag, input logic [9:0] flit, input logic [3:0] sel);
        chk({tag, "_valid"}, 32'(inj_valid), 32'd1);
        chk({tag, "_flit"},  32'(inj_flit),  32'(flit));
        chk({tag, "_sel"},   32'(inj_sel),   32'(sel));
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_flit  = 10'h000;
        slot_busy = 4'b0000;

        // Reset values while rst is held
        #1;
        chk("rst_ready", 32'(req_ready),    32'd1);
        chk("rst_valid", 32'(inj_valid),    32'd0);
        chk("rst_flit",  32'(inj_flit),     32'd0);
        chk("rst_sel",   32'(inj_sel),      32'd0);
        chk("rst_count", 32'(fifo_count),   32'd0);
        chk("rst_alarm", 32'(starve_alarm), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        chk("post_rst_ready", 32'(req_ready), 32'd1);

        // Single flit, path clear
        req_valid = 1'b1;
        req_flit  = 10'b1000100100;
        tick();
        req_valid = 1'b0;
        chk("single_e0_count", 32'(fifo_count), 32'd1);
        chk("single_e0_valid", 32'(inj_valid),  32'd0);
        tick();
        chk_pop("single_e1", 10'b1000100100, 4'b0001);
        chk("single_e1_count", 32'(fifo_count), 32'd0);
        tick();
        chk("single_idle_valid", 32'(inj_valid), 32'd0);
        chk("single_idle_sel",   32'(inj_sel),   32'd0);
        chk("single_idle_hold",  32'(inj_flit),  32'(10'b1000100100));

        // Round-robin rotation over four back-to-back flits
        pulse_reset();
        slot_busy = 4'b0000;
        req_valid = 1'b1;
        req_flit  = 10'h011;
        tick();
        req_flit  = 10'h022;
        tick();
        chk_pop("rr0", 10'h011, 4'b0001);
        chk("rr0_count", 32'(fifo_count), 32'd1);
        req_flit  = 10'h033;
        tick();
        chk_pop("rr1", 10'h022, 4'b0010);
        req_flit  = 10'h044;
        tick();
        chk_pop("rr2", 10'h033, 4'b0100);
        req_valid = 1'b0;
        tick();
        chk_pop("rr3", 10'h044, 4'b1000);
        chk("rr3_count", 32'(fifo_count), 32'd0);

        // Full FIFO with all slots busy, then release slot E
        pulse_reset();
        slot_busy = 4'b1111;
        req_valid = 1'b1;
        req_flit  = 10'h101;
        tick();
        req_flit  = 10'h102;
        tick();
        req_flit  = 10'h103;
        tick();
        req_flit  = 10'h104;
        tick();
        req_flit  = 10'h105;
        chk("full_count", 32'(fifo_count), 32'd4);
        chk("full_ready", 32'(req_ready),  32'd0);
        tick();
        chk("full_held_count", 32'(fifo_count), 32'd4);
        chk("full_held_valid", 32'(inj_valid),  32'd0);
        slot_busy = 4'b1011;
        tick();
        chk_pop("full_rel", 10'h101, 4'b0100);
        chk("full_rel_count", 32'(fifo_count), 32'd3);
        tick();
        chk_pop("full_pop1", 10'h102, 4'b0100);
        chk("full_pop1_count", 32'(fifo_count), 32'd3);
        req_valid = 1'b0;
        tick();
        chk_pop("full_pop2", 10'h103, 4'b0100);
        tick();
        chk_pop("full_pop3", 10'h104, 4'b0100);
        tick();
        chk_pop("full_wrap", 10'h105, 4'b0100);
        chk("full_drain_count", 32'(fifo_count), 32'd0);

        // Starvation alarm
        pulse_reset();
        slot_busy = 4'b1111;
        req_valid = 1'b1;
        req_flit  = 10'h2A5;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("starve_pre", 32'(starve_alarm), 32'd0);
        tick();
        chk("starve_rise", 32'(starve_alarm), 32'd1);
        tick();
        chk("starve_sat", 32'(starve_alarm), 32'd1);
        slot_busy = 4'b0111;
        tick();
        chk_pop("starve_pop", 10'h2A5, 4'b1000);
        chk("starve_fall", 32'(starve_alarm), 32'd0);

        // Simultaneous push and pop with two flits buffered
        pulse_reset();
        slot_busy = 4'b1111;
        req_valid = 1'b1;
        req_flit  = 10'h0A0;
        tick();
        req_flit  = 10'h0B0;
        tick();
        chk("sim_setup_count", 32'(fifo_count), 32'd2);
        slot_busy = 4'b0000;
        req_flit  = 10'h0C0;
        tick();
        req_valid = 1'b0;
        chk_pop("sim_pp", 10'h0A0, 4'b0001);
        chk("sim_pp_count", 32'(fifo_count), 32'd2);
        tick();
        chk_pop("sim_p1", 10'h0B0, 4'b0010);
        tick();
        chk_pop("sim_p2", 10'h0C0, 4'b0100);
        chk("sim_end_count", 32'(fifo_count), 32'd0);

        // Reset mid-operation with three flits buffered
        pulse_reset();
        slot_busy = 4'b1111;
        req_valid = 1'b1;
        req_flit  = 10'h301;
        tick();
        req_flit  = 10'h302;
        tick();
        req_flit  = 10'h303;
        tick();
        slot_busy = 4'b1110;
        req_flit  = 10'h304;
        tick();
        req_valid = 1'b0;
        chk_pop("mid_pre", 10'h301, 4'b0001);
        chk("mid_pre_count", 32'(fifo_count), 32'd3);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(inj_valid),    32'd0);
        chk("mid_rst_flit",  32'(inj_flit),     32'd0);
        chk("mid_rst_sel",   32'(inj_sel),      32'd0);
        chk("mid_rst_count", 32'(fifo_count),   32'd0);
        chk("mid_rst_ready", 32'(req_ready),    32'd1);
        chk("mid_rst_alarm", 32'(starve_alarm), 32'd0);
        #1;
        rst       = 1'b0;
        slot_busy = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mid_after_valid", 32'(inj_valid),  32'd0);
            chk("mid_after_count", 32'(fifo_count), 32'd0);
        end
        chk("mid_after_flit", 32'(inj_flit), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inject_sched.md
INJECT_SCHED -- requirements
Module: inject_sched

Interface
REQ-001 Parameter: DEPTH, default 4, number of local-injection FIFO entries (power of 2, at least 2).
REQ-002 Parameter: STARVE_LIMIT, default 8, count of consecutive blocked cycles that raises starve_alarm.
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous and active-high.
REQ-005 Port: req_valid  input  1  local core offers a flit.
REQ-006 Port: req_flit  input  10  offered flit (10-bit router flit word).
REQ-007 Port: req_ready  output  1  FIFO can accept a flit this cycle.
REQ-008 Port: slot_busy  input  4  router output slot occupancy: bit0 N, bit1 S, bit2 E, bit3 W; 1 means occupied.
REQ-009 Port: inj_valid  output  1  registered; a flit is injected this cycle.
REQ-010 Port: inj_flit  output  10  registered injected flit.
REQ-011 Port: inj_sel  output  4  registered one-hot slot select, same bit order as slot_busy.
REQ-012 Port: fifo_count  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-013 Port: starve_alarm  output  1  registered; the FIFO has been blocked for STARVE_LIMIT cycles.

Function
REQ-014 FIFO behaviour:
- req_ready SHALL equal (fifo_count < DEPTH), decoded combinationally from the registered count.
- No flit passes straight from input to output.
REQ-015 Push and pop ordering:
- A push occurs when req_valid && req_ready at a rising edge.
- Flits SHALL leave the FIFO in arrival order.
REQ-016 Pop condition: a pop SHALL occur at an edge when fifo_count > 0 and (~slot_busy) != 0.
REQ-017 Pop outputs: at a pop edge the block SHALL register the following, held for exactly one cycle:
- inj_valid = 1
- inj_flit = head flit
- inj_sel = one-hot chosen slot
REQ-018 When no pop occurs at an edge, the block SHALL register inj_valid = 0 and inj_sel = 0; inj_flit SHALL hold its previous value.
REQ-019 Slot choice SHALL be round-robin:
- Search free slots starting at rr_ptr (2-bit), in order rr_ptr, rr_ptr+1, ... mod 4.
- Take the first free slot found.
- After a pop, rr_ptr SHALL become (chosen index + 1) mod 4; otherwise it is unchanged.
REQ-020 Latency:
- A flit pushed into an empty FIFO at edge E0 SHALL be popped no earlier than edge E1.
- At E1 it is popped if a slot is free; inj_valid is high in the cycle after E1.
REQ-021 Simultaneous push and pop at one edge SHALL leave fifo_count unchanged; a full FIFO SHALL not accept a push even when it pops at the same edge.
REQ-022 Read and write pointers SHALL wrap modulo DEPTH without losing or duplicating flits.
REQ-023 FSM state SHALL be a registered value computed from fifo_count and slot_busy at each edge:
- IDLE when fifo_count == 0.
- READY when fifo_count > 0 and a slot is free.
- BLOCKED when fifo_count > 0 and slot_busy == 4'b1111.
REQ-024 Starvation counter (saturating, width $clog2(STARVE_LIMIT)+1):
- Increments at each edge where the FSM is in BLOCKED.
- Clears on any pop and on entry to IDLE.
- Saturates at STARVE_LIMIT.
REQ-025 starve_alarm SHALL be 1 exactly while the starvation counter equals STARVE_LIMIT, and SHALL fall in the cycle after the next pop.
REQ-026 The block SHALL not inspect or modify the contents of req_flit.

Reset
REQ-027 While rst = 1, the block SHALL asynchronously force all of the following:
- FIFO read and write pointers = 0
- fifo_count = 0
- rr_ptr = 0
- starvation counter = 0
- FSM state = IDLE
- inj_valid = 0
- inj_flit = 10'b0
- inj_sel = 4'b0000
- starve_alarm = 0
REQ-028 Consequently req_ready SHALL be 1 while rst = 1 and immediately after reset.
REQ-029 Reset asserted mid-operation SHALL discard all FIFO contents; no flit buffered before reset SHALL appear on inj_flit afterwards.

Verification
REQ-030 Single flit, path clear:
- Stimulus: slot_busy = 0000; push 10'b1000100100 at E0.
- Response: at E1, inj_valid = 1, inj_sel = 0001, inj_flit = 10'b1000100100; fifo_count returns to 0.
REQ-031 Round-robin rotation:
- Stimulus: slot_busy = 0000; push 4 flits back-to-back.
- Response: inj_sel sequence 0001, 0010, 0100, 1000, in push order.
REQ-032 Full FIFO and blocked slots:
- Stimulus: slot_busy = 1111; push 5 flits.
- Response: 4 accepted; req_ready = 0 with fifo_count = 4; the 5th flit is held off.
- Stimulus: then release slot_busy to 1011.
- Response: head flit injected with inj_sel = 0100.
REQ-033 Starvation alarm:
- Stimulus: slot_busy = 1111 with 1 flit buffered.
- Response: starve_alarm rises after 8 BLOCKED edges.
- Stimulus: set slot_busy = 0111.
- Response: pop with inj_sel = 1000; starve_alarm = 0 one cycle later.
REQ-034 Simultaneous push and pop:
- Stimulus: fifo_count = 2, a slot free, req_valid = 1.
- Response: fifo_count stays 2 and order is preserved.
REQ-035 Reset mid-operation:
- Stimulus: assert rst with 3 flits buffered.
- Response: outputs go immediately to their reset values; after release, no old flit appears and fifo_count = 0.
